// File: rtl/cpu_bus_responder.sv
// ---------------------------------------------------------------------------
// cpu_bus_responder
//
// Responder for the CPU's three bus interfaces (instruction ROM, data RAM,
// I/O port space) plus a periodic interrupt timer.
//
// Every bus has its own channel FSM (IDLE -> WAIT -> ACK -> IDLE). The FSM
// counts a fixed number of wait states and then raises a one-cycle ack. The
// address, write data and write enable are used on the edge that enters ACK.
// On that same edge:
//   - read data is captured into the dat_o register, which then holds, and
//   - writes to the RAM or to the port registers are performed.
// Dropping cyc while the channel is waiting abandons the transfer. No ack is
// given, nothing is written, and the read data register keeps its value.
//
// Ports
//   clk_i, rst_i            clock (rising edge), asynchronous active-high reset
//   inst_cyc/stb/adr_i      instruction bus request, 12-bit word address
//   inst_dat_o/ack_o        18-bit instruction word, ack pulse
//   data_cyc/stb/we/adr/dat_i  data bus request, 8-bit address/data
//   data_dat_o/ack_o        8-bit read data, ack pulse
//   port_cyc/stb/we/adr/dat_i  port bus request, 8-bit address/data
//   port_dat_o/ack_o        8-bit port read data, ack pulse
//   port_in0_i/port_in1_i   external input ports (read at 0x00 / 0x01)
//   port_out0_o/port_out1_o output port registers (written at 0x00 / 0x01)
//   int_ack_i               interrupt acknowledge from the CPU
//   int_req_o               interrupt request, set by the timer
// ---------------------------------------------------------------------------

// One bus channel: wait-state counter and ack sequencing.
// xfer_o is high during the cycle whose closing edge enters ACK. The parent
// module performs the data transfer on that edge.
module cpu_bus_channel #(
  parameter int unsigned WAIT = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cyc_i,
  input  logic stb_i,
  output logic xfer_o,
  output logic ack_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [2:0] WAIT_CNT = 3'(WAIT);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xfer_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cyc_i && stb_i) begin
          if (WAIT_CNT == 3'd0) begin
            state_d = ST_ACK;
            xfer_o  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_CNT;
          end
        end
      end
      ST_WAIT: begin
        // Abort has priority, even on the cycle that would otherwise enter ACK.
        if (!cyc_i) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else if (cnt_q == 3'd1) begin
          state_d = ST_ACK;
          xfer_o  = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_ACK: begin
        // Always returns to IDLE, so at least one idle cycle lies between
        // two transactions.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ack_o = (state_q == ST_ACK);

endmodule

module cpu_bus_responder #(
  parameter int unsigned INST_WAIT  = 1,
  parameter int unsigned DATA_WAIT  = 2,
  parameter int unsigned PORT_WAIT  = 0,
  parameter string       INST_FILE  = "gasm_text.dat",
  parameter string       DATA_FILE  = "gasm_data.dat",
  parameter logic [15:0] TMR_PERIOD = 16'd1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // instruction bus
  input  logic        inst_cyc_i,
  input  logic        inst_stb_i,
  input  logic [11:0] inst_adr_i,
  output logic [17:0] inst_dat_o,
  output logic        inst_ack_o,
  // data bus
  input  logic        data_cyc_i,
  input  logic        data_stb_i,
  input  logic        data_we_i,
  input  logic [7:0]  data_adr_i,
  input  logic [7:0]  data_dat_i,
  output logic [7:0]  data_dat_o,
  output logic        data_ack_o,
  // port bus
  input  logic        port_cyc_i,
  input  logic        port_stb_i,
  input  logic        port_we_i,
  input  logic [7:0]  port_adr_i,
  input  logic [7:0]  port_dat_i,
  output logic [7:0]  port_dat_o,
  output logic        port_ack_o,
  // external ports
  input  logic [7:0]  port_in0_i,
  input  logic [7:0]  port_in1_i,
  output logic [7:0]  port_out0_o,
  output logic [7:0]  port_out1_o,
  // interrupt
  input  logic        int_ack_i,
  output logic        int_req_o
);

  localparam logic [7:0]  PORT_ADR_IO0 = 8'h00;
  localparam logic [7:0]  PORT_ADR_IO1 = 8'h01;
  localparam logic [7:0]  PORT_ADR_TMR = 8'h02;
  localparam logic [15:0] TMR_LAST     = TMR_PERIOD - 16'd1;

  // ------------------------------------------------------------------
  // Channel sequencers
  // ------------------------------------------------------------------
  logic inst_xfer, data_xfer, port_xfer;

  cpu_bus_channel #(.WAIT(INST_WAIT)) u_inst_chan (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .cyc_i  (inst_cyc_i),
    .stb_i  (inst_stb_i),
    .xfer_o (inst_xfer),
    .ack_o  (inst_ack_o)
  );

  cpu_bus_channel #(.WAIT(DATA_WAIT)) u_data_chan (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .cyc_i  (data_cyc_i),
    .stb_i  (data_stb_i),
    .xfer_o (data_xfer),
    .ack_o  (data_ack_o)
  );

  cpu_bus_channel #(.WAIT(PORT_WAIT)) u_port_chan (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .cyc_i  (port_cyc_i),
    .stb_i  (port_stb_i),
    .xfer_o (port_xfer),
    .ack_o  (port_ack_o)
  );

  // ------------------------------------------------------------------
  // Memories (contents survive reset)
  // ------------------------------------------------------------------
  logic [17:0] rom_mem [0:4095];
  logic [7:0]  ram_mem [0:255];

  // A write whose ACK edge coincides with reset is dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i && data_xfer && data_we_i) begin
      ram_mem[data_adr_i] <= data_dat_i;
    end
  end

  // ------------------------------------------------------------------
  // Registered state
  // ------------------------------------------------------------------
  logic [17:0] inst_dat_q, inst_dat_d;
  logic [7:0]  data_dat_q, data_dat_d;
  logic [7:0]  port_dat_q, port_dat_d;
  logic [7:0]  port_out0_q, port_out0_d;
  logic [7:0]  port_out1_q, port_out1_d;
  logic        tmr_en_q, tmr_en_d;
  logic [15:0] timer_q, timer_d;
  logic        int_req_q, int_req_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inst_dat_q  <= 18'd0;
      data_dat_q  <= 8'd0;
      port_dat_q  <= 8'd0;
      port_out0_q <= 8'd0;
      port_out1_q <= 8'd0;
      tmr_en_q    <= 1'b0;
      timer_q     <= 16'd0;
      int_req_q   <= 1'b0;
    end else begin
      inst_dat_q  <= inst_dat_d;
      data_dat_q  <= data_dat_d;
      port_dat_q  <= port_dat_d;
      port_out0_q <= port_out0_d;
      port_out1_q <= port_out1_d;
      tmr_en_q    <= tmr_en_d;
      timer_q     <= timer_d;
      int_req_q   <= int_req_d;
    end
  end

  // ------------------------------------------------------------------
  // Instruction and data read capture
  // ------------------------------------------------------------------
  always_comb begin
    inst_dat_d = inst_dat_q;
    data_dat_d = data_dat_q;
    if (inst_xfer) begin
      inst_dat_d = rom_mem[inst_adr_i];
    end
    if (data_xfer && !data_we_i) begin
      data_dat_d = ram_mem[data_adr_i];
    end
  end

  // ------------------------------------------------------------------
  // Port space
  // ------------------------------------------------------------------
  logic [7:0] port_rd;

  always_comb begin
    case (port_adr_i)
      PORT_ADR_IO0: port_rd = port_in0_i;
      PORT_ADR_IO1: port_rd = port_in1_i;
      PORT_ADR_TMR: port_rd = {7'b0, tmr_en_q};
      default:      port_rd = 8'h00;
    endcase
  end

  always_comb begin
    port_dat_d  = port_dat_q;
    port_out0_d = port_out0_q;
    port_out1_d = port_out1_q;
    tmr_en_d    = tmr_en_q;
    if (port_xfer) begin
      if (port_we_i) begin
        case (port_adr_i)
          PORT_ADR_IO0: port_out0_d = port_dat_i;
          PORT_ADR_IO1: port_out1_d = port_dat_i;
          PORT_ADR_TMR: tmr_en_d    = port_dat_i[0];
          default:      ;
        endcase
      end else begin
        port_dat_d = port_rd;
      end
    end
  end

  // ------------------------------------------------------------------
  // Interrupt timer
  // ------------------------------------------------------------------
  logic tmr_hit;

  always_comb begin
    timer_d = 16'd0;
    tmr_hit = 1'b0;
    // A disabled timer is held at zero, so re-enabling starts a full period.
    if (tmr_en_q) begin
      if (timer_q == TMR_LAST) begin
        tmr_hit = 1'b1;
      end else begin
        timer_d = timer_q + 16'd1;
      end
    end
  end

  // A terminal count wins over an acknowledge in the same cycle.
  always_comb begin
    int_req_d = int_req_q;
    if (tmr_hit) begin
      int_req_d = 1'b1;
    end else if (int_ack_i) begin
      int_req_d = 1'b0;
    end
  end

  assign inst_dat_o  = inst_dat_q;
  assign data_dat_o  = data_dat_q;
  assign port_dat_o  = port_dat_q;
  assign port_out0_o = port_out0_q;
  assign port_out1_o = port_out1_q;
  assign int_req_o   = int_req_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
module tb_cpu_bus_responder;

  localparam int IW = 1;
  localparam int DW = 2;
  localparam int PW = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_cyc, inst_stb;
  logic [11:0] inst_adr;
  logic [17:0] inst_dat;
  logic        inst_ack;
  logic        data_cyc, data_stb, data_we;
  logic [7:0]  data_adr, data_wdat, data_rdat;
  logic        data_ack;
  logic        port_cyc, port_stb, port_we;
  logic [7:0]  port_adr, port_wdat, port_rdat;
  logic        port_ack;
  logic [7:0]  port_in0, port_in1, port_out0, port_out1;
  logic        int_ack, int_req;

  cpu_bus_responder #(
    .INST_WAIT (IW),
    .DATA_WAIT (DW),
    .PORT_WAIT (PW),
    .INST_FILE (""),
    .DATA_FILE (""),
    .TMR_PERIOD(16'd10)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .inst_cyc_i (inst_cyc),
    .inst_stb_i (inst_stb),
    .inst_adr_i (inst_adr),
    .inst_dat_o (inst_dat),
    .inst_ack_o (inst_ack),
    .data_cyc_i (data_cyc),
    .data_stb_i (data_stb),
    .data_we_i  (data_we),
    .data_adr_i (data_adr),
    .data_dat_i (data_wdat),
    .data_dat_o (data_rdat),
    .data_ack_o (data_ack),
    .port_cyc_i (port_cyc),
    .port_stb_i (port_stb),
    .port_we_i  (port_we),
    .port_adr_i (port_adr),
    .port_dat_i (port_wdat),
    .port_dat_o (port_rdat),
    .port_ack_o (port_ack),
    .port_in0_i (port_in0),
    .port_in1_i (port_in1),
    .port_out0_o(port_out0),
    .port_out1_o(port_out1),
    .int_ack_i  (int_ack),
    .int_req_o  (int_req)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [17:0] rom_m [0:15];
  logic [7:0]  ram_m [0:255];
  bit          ram_v [0:255];
  logic [7:0]  out0_m, out1_m;
  bit          tmr_en_m;

  typedef struct {
    int          kind;   // 0 inst, 1 data, 2 port
    bit          we;
    logic [11:0] adr;
    logic [7:0]  wdat;
    logic [7:0]  in0;
    logic [7:0]  in1;
    logic [17:0] exp;    // read data, or {out1,out0} after a port write
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lat_exp(input int kind);
    if (kind == 0) return IW + 1;
    if (kind == 1) return DW + 1;
    return PW + 1;
  endfunction

  function automatic logic ack_of(input int kind);
    if (kind == 0) return inst_ack;
    if (kind == 1) return data_ack;
    return port_ack;
  endfunction

  function automatic logic [17:0] dat_of(input int kind);
    if (kind == 0) return inst_dat;
    if (kind == 1) return {10'b0, data_rdat};
    return {10'b0, port_rdat};
  endfunction

  task automatic drive(input int kind, input bit on, input bit we,
                       input logic [11:0] adr, input logic [7:0] wdat);
    case (kind)
      0: begin inst_cyc = on; inst_stb = on; inst_adr = adr; end
      1: begin data_cyc = on; data_stb = on; data_we = we; data_adr = adr[7:0]; data_wdat = wdat; end
      default: begin port_cyc = on; port_stb = on; port_we = we; port_adr = adr[7:0]; port_wdat = wdat; end
    endcase
  endtask

  // lat = clock edges from presenting the request until ack is seen high.
  task automatic xact(input int kind, input bit we, input logic [11:0] adr, input logic [7:0] wdat,
                      output logic [17:0] rd, output logic [17:0] rd_hold,
                      output int lat, output bit one_cycle);
    bit seen;
    seen = 0; lat = 0; one_cycle = 0; rd = '0; rd_hold = '0;
    @(negedge clk);
    drive(kind, 1'b1, we, adr, wdat);
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (ack_of(kind)) begin
        seen = 1; lat = i; rd = dat_of(kind);
      end
    end
    drive(kind, 1'b0, we, adr, wdat);
    if (seen) begin
      @(negedge clk);
      one_cycle = !ack_of(kind);
      rd_hold   = dat_of(kind);
    end
  endtask

  function automatic logic [7:0] port_read_m(input logic [11:0] adr);
    if (adr == 12'h000) return port_in0;
    if (adr == 12'h001) return port_in1;
    if (adr == 12'h002) return {7'b0, tmr_en_m};
    return 8'h00;
  endfunction

  // Run one transaction and compare: latency, ack width, read data and hold,
  // or output-port registers after a port write. Updates the model afterwards.
  task automatic txn(input int kind, input bit we, input logic [11:0] adr, input logic [7:0] wdat,
                     input logic [17:0] exp, input bit exp_valid, input string tag);
    logic [17:0] rd, rd_hold;
    int lat;
    bit one;
    xact(kind, we, adr, wdat, rd, rd_hold, lat, one);
    $display("%s kind=%0d we=%0b adr=%h wdat=%h rd=%h lat=%0d", tag, kind, we, adr, wdat, rd, lat);
    chk({tag, "_lat"}, lat, lat_exp(kind));
    chk({tag, "_ack1"}, {31'b0, one}, 32'd1);
    if (exp_valid) begin
      if (kind == 2 && we) begin
        chk({tag, "_outs"}, {16'b0, port_out1, port_out0}, {14'b0, exp});
      end else if (!we || kind == 0) begin
        chk({tag, "_rd"}, rd, exp);
        chk({tag, "_hold"}, rd_hold, exp);
      end
    end
    if (kind == 1 && we) begin
      ram_m[adr[7:0]] = wdat; ram_v[adr[7:0]] = 1;
    end
    if (kind == 2 && we) begin
      if (adr == 12'h000) out0_m = wdat;
      if (adr == 12'h001) out1_m = wdat;
      if (adr == 12'h002) tmr_en_m = wdat[0];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] rd_i, rd_d, rd_p, h_i, h_d, h_p, exp;
    int lat_i, lat_d, lat_p, acks;
    bit one_i, one_d, one_p, valid, seen;
    int kind;
    bit we;
    logic [11:0] adr;
    logic [7:0] wdat;

    rst = 1'b1;
    inst_cyc = 0; inst_stb = 0; inst_adr = '0;
    data_cyc = 0; data_stb = 0; data_we = 0; data_adr = '0; data_wdat = '0;
    port_cyc = 0; port_stb = 0; port_we = 0; port_adr = '0; port_wdat = '0;
    port_in0 = '0; port_in1 = '0; int_ack = 0;
    out0_m = 0; out1_m = 0; tmr_en_m = 0;
    for (int i = 0; i < 256; i++) begin ram_m[i] = 0; ram_v[i] = 0; end

    // ROM image written straight into the array (no image file in this bench)
    for (int i = 0; i < 16; i++) rom_m[i] = 18'($urandom);
    rom_m[0] = 18'h15555;
    rom_m[5] = 18'h38668;
    for (int i = 0; i < 16; i++) dut.rom_mem[i] = rom_m[i];
    dut.rom_mem[12'hFFF] = 18'h2AAAA;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_acks", {29'b0, inst_ack, data_ack, port_ack}, 32'd0);
    chk("rst_dats", {6'b0, inst_dat, data_rdat}, 32'd0);
    chk("rst_port", {16'b0, port_rdat, port_out1}, 32'd0);
    chk("rst_out0_int", {23'b0, port_out0, int_req}, 32'd0);
    rst = 1'b0;

    // Directed vectors
    vecs[0]  = '{0, 0, 12'h005, 8'h00, 8'h00, 8'h00, 18'h38668};
    vecs[1]  = '{0, 0, 12'hFFF, 8'h00, 8'h00, 8'h00, 18'h2AAAA};
    vecs[2]  = '{1, 1, 12'h011, 8'h5C, 8'h00, 8'h00, 18'h0};
    vecs[3]  = '{1, 1, 12'h010, 8'hA5, 8'h00, 8'h00, 18'h0};
    vecs[4]  = '{1, 0, 12'h010, 8'h00, 8'h00, 8'h00, 18'h000A5};
    vecs[5]  = '{1, 0, 12'h011, 8'h00, 8'h00, 8'h00, 18'h0005C};
    vecs[6]  = '{2, 1, 12'h001, 8'h3C, 8'h00, 8'h00, 18'h03C00};
    vecs[7]  = '{2, 0, 12'h000, 8'h00, 8'h5A, 8'h00, 18'h0005A};
    vecs[8]  = '{2, 0, 12'h007, 8'h00, 8'h5A, 8'h77, 18'h00000};
    vecs[9]  = '{2, 0, 12'h001, 8'h00, 8'h00, 8'hC3, 18'h000C3};
    vecs[10] = '{2, 1, 12'h000, 8'h81, 8'h00, 8'h00, 18'h03C81};
    vecs[11] = '{2, 1, 12'h005, 8'hFF, 8'h00, 8'h00, 18'h03C81};
    vecs[12] = '{2, 0, 12'h002, 8'h00, 8'h00, 8'h00, 18'h00000};
    vecs[13] = '{0, 0, 12'h000, 8'h00, 8'h00, 8'h00, 18'h15555};
    for (int v = 0; v < 14; v++) begin
      port_in0 = vecs[v].in0;
      port_in1 = vecs[v].in1;
      txn(vecs[v].kind, vecs[v].we, vecs[v].adr, vecs[v].wdat, vecs[v].exp, 1'b1,
          $sformatf("vec%0d", v));
    end

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 2));
      we   = 1'($urandom_range(0, 1));
      wdat = 8'($urandom);
      port_in0 = 8'($urandom);
      port_in1 = 8'($urandom);
      if (kind == 0) begin
        we = 0; adr = 12'($urandom_range(0, 15));
        exp = rom_m[adr[3:0]]; valid = 1;
      end else if (kind == 1) begin
        adr = 12'(8'h40 + 8'($urandom_range(0, 15)));
        exp = {10'b0, ram_m[adr[7:0]]}; valid = !we && ram_v[adr[7:0]];
      end else begin
        adr = 12'($urandom_range(0, 4));
        valid = 1;
        if (we) begin
          exp = {2'b0, (adr == 12'h001) ? wdat : out1_m, (adr == 12'h000) ? wdat : out0_m};
        end else begin
          exp = {10'b0, port_read_m(adr)};
        end
      end
      txn(kind, we, adr, wdat, exp, valid, $sformatf("rnd%0d", n));
    end

    // All three buses requested on the same edge
    port_in1 = 8'h6E;
    fork
      xact(0, 1'b0, 12'h005, 8'h00, rd_i, h_i, lat_i, one_i);
      xact(1, 1'b0, 12'h010, 8'h00, rd_d, h_d, lat_d, one_d);
      xact(2, 1'b0, 12'h001, 8'h00, rd_p, h_p, lat_p, one_p);
    join
    $display("par inst lat=%0d data lat=%0d port lat=%0d", lat_i, lat_d, lat_p);
    chk("par_inst_lat", lat_i, IW + 1);
    chk("par_data_lat", lat_d, DW + 1);
    chk("par_port_lat", lat_p, PW + 1);
    chk("par_inst_rd", rd_i, 18'h38668);
    chk("par_data_rd", rd_d, 18'h000A5);
    chk("par_port_rd", rd_p, 18'h0006E);
    chk("par_ack1", {29'b0, one_i, one_d, one_p}, 32'd7);

    // Abort during WAIT
    txn(1, 1'b1, 12'h020, 8'h11, 18'h0, 1'b0, "abort_pre_wr");
    txn(1, 1'b0, 12'h020, 8'h00, 18'h00011, 1'b1, "abort_pre_rd");
    @(negedge clk); drive(1, 1'b1, 1'b1, 12'h020, 8'h77);
    @(negedge clk); drive(1, 1'b0, 1'b1, 12'h020, 8'h77);
    acks = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (data_ack) acks++; end
    $display("abort write adr=20 acks=%0d", acks);
    chk("abort_wr_noack", acks, 0);
    @(negedge clk); drive(1, 1'b1, 1'b0, 12'h010, 8'h00);
    @(negedge clk); drive(1, 1'b0, 1'b0, 12'h010, 8'h00);
    acks = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (data_ack) acks++; end
    $display("abort read adr=10 acks=%0d dat=%h", acks, data_rdat);
    chk("abort_rd_noack", acks, 0);
    chk("abort_rd_dat_kept", {24'b0, data_rdat}, 32'h11);
    txn(1, 1'b0, 12'h020, 8'h00, 18'h00011, 1'b1, "abort_post_rd");

    // Interrupt timer, period 10
    txn(2, 1'b1, 12'h002, 8'h00, {2'b0, out1_m, out0_m}, 1'b1, "tmr_off");
    @(negedge clk); int_ack = 1;
    @(negedge clk); int_ack = 0;
    @(negedge clk);
    chk("int_cleared", {31'b0, int_req}, 32'd0);
    @(negedge clk); drive(2, 1'b1, 1'b1, 12'h002, 8'h01);
    @(posedge clk);                      // enabling edge
    @(negedge clk); drive(2, 1'b0, 1'b1, 12'h002, 8'h01);
    tmr_en_m = 1;
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk); #1;
      if (k == 9)  chk("int_before_tc", {31'b0, int_req}, 32'd0);
      if (k == 10) begin chk("int_at_tc", {31'b0, int_req}, 32'd1); int_ack = 1; end
      if (k == 11) begin chk("int_acked", {31'b0, int_req}, 32'd0); int_ack = 0; end
      if (k == 19) begin chk("int_idle", {31'b0, int_req}, 32'd0); int_ack = 1; end
      if (k == 20) chk("int_set_wins", {31'b0, int_req}, 32'd1);
      if (k == 21) begin chk("int_held_ack", {31'b0, int_req}, 32'd0); int_ack = 0; end
    end
    $display("timer sequence done int_req=%0b", int_req);
    txn(2, 1'b1, 12'h002, 8'h00, {2'b0, out1_m, out0_m}, 1'b1, "tmr_stop");

    // Reset while a write is waiting: no ack, no write, outputs cleared
    txn(1, 1'b1, 12'h030, 8'h44, 18'h0, 1'b0, "rst_pre_wr");
    @(negedge clk); drive(1, 1'b1, 1'b1, 12'h030, 8'h99);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("rst_wait_ack", {31'b0, data_ack}, 32'd0);
    chk("rst_wait_outs", {8'b0, port_out1, port_out0, data_rdat}, 32'd0);
    drive(1, 1'b0, 1'b1, 12'h030, 8'h99);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    out0_m = 0; out1_m = 0; tmr_en_m = 0;
    $display("reset during data wait released");
    txn(1, 1'b0, 12'h030, 8'h00, 18'h00044, 1'b1, "rst_post_rd");

    // Reset while ack is high drops it at once
    @(negedge clk); drive(0, 1'b1, 1'b0, 12'h005, 8'h00);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); if (inst_ack) seen = 1;
    end
    chk("rst_ack_seen", {31'b0, seen}, 32'd1);
    #2 rst = 1'b1;
    #1;
    $display("reset during inst ack: ack=%0b dat=%h", inst_ack, inst_dat);
    chk("rst_ack_drop", {31'b0, inst_ack}, 32'd0);
    chk("rst_ack_dat", {14'b0, inst_dat}, 32'd0);
    drive(0, 1'b0, 1'b0, 12'h005, 8'h00);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    txn(0, 1'b0, 12'h005, 8'h00, 18'h38668, 1'b1, "rst_post_inst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
